audio_fx_engine: RTL and testbench

Parametrised stereo audio effects stage inserted in the stream between the I2S receiver and I2S transmitter, replacing the direct pass-through. It accepts one stereo frame at a time on a ready/valid stream and applies a switch-selected mode: pass, mute, channel swap, mono sum or feedback echo. It emits the processed frame with saturation. A block-RAM delay line of DELAY_DEPTH frames backs the echo; the block clears it after reset and on request.

---
 rtl/audio_fx_engine.sv | 197 +++++++++++++++++++
 tb/tb_audio_fx_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_fx_engine.sv
// Stereo effects stage between the I2S receiver and transmitter: pass, mute, swap,
// mono and feedback echo, with a block-RAM delay line that is cleared after reset and on request.
module audio_fx_engine #(
    parameter int DATA_WIDTH  = 24,
    parameter int DELAY_DEPTH = 4096,
    parameter int FB_SHIFT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            mode,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_lc,
    input  logic [DATA_WIDTH-1:0] s_rc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_lc,
    output logic [DATA_WIDTH-1:0] m_rc,
    output logic                  busy,
    output logic                  clip,
    output logic [1:0]            state_dbg
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = $clog2(DELAY_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DELAY_DEPTH - 1);
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        CALC  = 2'd2,
        OUT   = 2'd3
    } fsm_state_e;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never waits on ready, and payload is held stable while valid && !ready.

    fsm_state_e     state_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  wp_q;
    logic           clr_pend_q;
    logic [DW-1:0]  x_l_q, x_r_q;
    logic [2:0]     mode_q;
    logic [DW-1:0]  m_lc_q, m_rc_q;
    logic           m_valid_q;
    logic           s_ready_q;
    logic           busy_q;

    logic [2*DW-1:0] mem_q [DELAY_DEPTH];
    logic [2*DW-1:0] rd_q;

    logic            accept;
    logic            pend_now;
    logic signed [DW-1:0] dl_s, dr_s;
    logic [DW:0]     sum_l, sum_r, msum;
    logic            ovf_l, ovf_r;
    logic [DW-1:0]   e_l, e_r;
    logic [DW-1:0]   sel_l, sel_r;
    logic            sel_clip;
    logic            mem_we, mem_re;
    logic [AW-1:0]   mem_waddr;
    logic [2*DW-1:0] mem_wdata;

    assign accept   = s_valid && s_ready_q;
    assign pend_now = clr_pend_q || clr;

    always_comb begin
        dl_s  = $signed(rd_q[2*DW-1:DW]) >>> FB_SHIFT;
        dr_s  = $signed(rd_q[DW-1:0]) >>> FB_SHIFT;
        sum_l = {x_l_q[DW-1], x_l_q} + {dl_s[DW-1], dl_s};
        sum_r = {x_r_q[DW-1], x_r_q} + {dr_s[DW-1], dr_s};
        ovf_l = sum_l[DW] != sum_l[DW-1];
        ovf_r = sum_r[DW] != sum_r[DW-1];
        e_l   = ovf_l ? (sum_l[DW] ? SAT_MIN : SAT_MAX) : sum_l[DW-1:0];
        e_r   = ovf_r ? (sum_r[DW] ? SAT_MIN : SAT_MAX) : sum_r[DW-1:0];
        msum  = {x_l_q[DW-1], x_l_q} + {x_r_q[DW-1], x_r_q};

        sel_l    = x_l_q;
        sel_r    = x_r_q;
        sel_clip = 1'b0;
        case (mode_q)
            3'd1: begin
                sel_l = '0;
                sel_r = '0;
            end
            3'd2: begin
                sel_l = x_r_q;
                sel_r = x_l_q;
            end
            3'd3: begin
                sel_l = msum[DW:1];
                sel_r = msum[DW:1];
            end
            3'd4: begin
                sel_l    = e_l;
                sel_r    = e_r;
                sel_clip = ovf_l || ovf_r;
            end
            default: ;
        endcase
    end

    // The delay line takes the echo mix in every mode so history is ready when echo is selected.
    always_comb begin
        mem_we    = (state_q == CLEAR) || (state_q == CALC);
        mem_waddr = (state_q == CLEAR) ? addr_q : wp_q;
        mem_wdata = (state_q == CLEAR) ? '0 : {e_l, e_r};
        mem_re    = (state_q == IDLE) && accept;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        if (mem_re) rd_q <= mem_q[wp_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            addr_q     <= '0;
            wp_q       <= '0;
            clr_pend_q <= 1'b0;
            x_l_q      <= '0;
            x_r_q      <= '0;
            mode_q     <= '0;
            m_lc_q     <= '0;
            m_rc_q     <= '0;
            m_valid_q  <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    addr_q <= addr_q + AW'(1);
                    if (addr_q == LAST_ADDR) begin
                        state_q   <= IDLE;
                        wp_q      <= '0;
                        busy_q    <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        x_l_q      <= s_lc;
                        x_r_q      <= s_rc;
                        mode_q     <= mode;
                        s_ready_q  <= 1'b0;
                        clr_pend_q <= pend_now;
                        state_q    <= CALC;
                    end else if (pend_now) begin
                        state_q    <= CLEAR;
                        clr_pend_q <= 1'b0;
                        addr_q     <= '0;
                        busy_q     <= 1'b1;
                        s_ready_q  <= 1'b0;
                    end
                end
                CALC: begin
                    clr_pend_q <= pend_now;
                    wp_q       <= wp_q + AW'(1);
                    m_lc_q     <= sel_l;
                    m_rc_q     <= sel_r;
                    m_valid_q  <= 1'b1;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid_q  <= 1'b0;
                        clr_pend_q <= 1'b0;
                        if (pend_now) begin
                            state_q <= CLEAR;
                            addr_q  <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q   <= IDLE;
                            s_ready_q <= 1'b1;
                        end
                    end else begin
                        clr_pend_q <= pend_now;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_lc      = m_lc_q;
    assign m_rc      = m_rc_q;
    assign busy      = busy_q;
    assign clip      = (state_q == CALC) && sel_clip;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_audio_fx_engine.sv
// Directed and randomized bench for audio_fx_engine with a queue-based delay-line model.
module tb_audio_fx_engine;

    localparam int DW = 24;
    localparam int DD = 16;
    localparam int FB = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    mode = '0;
    logic          clr = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_lc = '0;
    logic [DW-1:0] s_rc = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_lc, m_rc;
    logic          busy, clip;
    logic [1:0]    state_dbg;

    int checks = 0;
    int failures = 0;
    int dq_l[$];
    int dq_r[$];

    always #5 clk = ~clk;

    audio_fx_engine #(.DATA_WIDTH(DW), .DELAY_DEPTH(DD), .FB_SHIFT(FB)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_lc(s_lc), .s_rc(s_rc),
        .m_valid(m_valid), .m_ready(m_ready), .m_lc(m_lc), .m_rc(m_rc),
        .busy(busy), .clip(clip), .state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    task automatic model_clear();
        dq_l = {};
        dq_r = {};
        for (int i = 0; i < DD; i++) begin
            dq_l.push_back(0);
            dq_r.push_back(0);
        end
    endtask

    // Echo history as a FIFO of the last DD mixed frames.
    task automatic model_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int md,
                               output int ol, output int orr, output bit oclip);
        int xl, xr, dl, dr, sl, sr, el, er;
        xl = $signed(l);
        xr = $signed(r);
        dl = dq_l.pop_front();
        dr = dq_r.pop_front();
        sl = xl + (dl >>> FB);
        sr = xr + (dr >>> FB);
        el = sat(sl);
        er = sat(sr);
        dq_l.push_back(el);
        dq_r.push_back(er);
        oclip = 1'b0;
        case (md)
            1: begin ol = 0; orr = 0; end
            2: begin ol = xr; orr = xl; end
            3: begin ol = (xl + xr) >>> 1; orr = ol; end
            4: begin ol = el; orr = er; oclip = (el != sl) || (er != sr); end
            default: begin ol = xl; orr = xr; end
        endcase
    endtask

    task automatic wait_clear(input string tag, input bit poke);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            chk({tag, "_busy_ready"}, {s_ready, m_valid}, 2'b00);
            clr = (poke && n == 5);
            n++;
            @(posedge clk); #1;
        end
        clr = 1'b0;
        chk({tag, "_len"}, n, DD);
        chk({tag, "_exit_ready"}, s_ready, 1'b1);
        @(posedge clk); #1;
        chk({tag, "_stay_idle"}, {busy, s_ready}, 2'b01);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        wait_clear("clr", 1'b0);
        model_clear();
    endtask

    task automatic do_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic [2:0] md,
                            input bit with_clr, input int hold,
                            output logic [DW-1:0] obs_l, output logic [DW-1:0] obs_r);
        int el, er, n;
        bit ec;
        model_frame(l, r, int'(md), el, er, ec);
        s_lc = l;
        s_rc = r;
        mode = md;
        s_valid = 1'b1;
        clr = with_clr;
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", n < 200, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        clr = 1'b0;
        mode = 3'($urandom_range(0, 7));
        s_lc = 24'($urandom);
        chk("calc_clip", clip, ec);
        chk("calc_no_valid", {m_valid, s_ready}, 2'b00);
        @(posedge clk); #1;
        chk("out_valid", m_valid, 1'b1);
        chk("out_data", {m_lc, m_rc}, {el[DW-1:0], er[DW-1:0]});
        chk("out_clip_low", clip, 1'b0);
        obs_l = m_lc;
        obs_r = m_rc;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_data", {m_valid, m_lc, m_rc}, {1'b1, el[DW-1:0], er[DW-1:0]});
            chk("hold_sready", s_ready, 1'b0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("after_hs_valid", m_valid, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] ol, orr;
        logic [DW-1:0] ext [4];
        logic [DW-1:0] a, b;
        logic [2:0]    md;
        ext[0] = 24'h7FFFFF; ext[1] = 24'h800000; ext[2] = 24'h000000; ext[3] = 24'hFFFFFF;

        // Reset state and post-reset clear
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {busy, s_ready, m_valid, clip}, 4'b1000);
        chk("rst_data", {m_lc, m_rc}, 48'h0);
        rst_n = 1'b1;
        wait_clear("reset", 1'b1);
        chk("rst_data_after", {m_lc, m_rc, m_valid}, 49'h0);
        model_clear();

        // Directed modes
        do_frame(24'h123456, 24'hFEDCBA, 3'd0, 1'b0, 0, ol, orr);
        chk("pass", {ol, orr}, {24'h123456, 24'hFEDCBA});
        chk("ready_after_hs", s_ready, 1'b1);
        do_frame(24'h123456, 24'hFEDCBA, 3'd1, 1'b0, 0, ol, orr);
        chk("mute", {ol, orr}, 48'h0);
        do_frame(24'd100, 24'hFFFED4, 3'd2, 1'b0, 0, ol, orr);
        chk("swap", {ol, orr}, {24'hFFFED4, 24'h000064});
        do_frame(24'd100, 24'hFFFED4, 3'd3, 1'b0, 0, ol, orr);
        chk("mono", {ol, orr}, {24'hFFFF9C, 24'hFFFF9C});
        do_frame(24'h7FFFFF, 24'h7FFFFF, 3'd3, 1'b0, 0, ol, orr);
        chk("mono_max", {ol, orr}, {24'h7FFFFF, 24'h7FFFFF});
        do_frame(24'h000055, 24'h0000AA, 3'd6, 1'b0, 0, ol, orr);
        chk("mode6_pass", {ol, orr}, {24'h000055, 24'h0000AA});

        // Echo impulse response
        pulse_clr();
        for (int k = 0; k <= 2 * DD; k++) begin
            do_frame((k == 0) ? 24'h100000 : 24'h0, 24'h0, 3'd4, 1'b0, 0, ol, orr);
            chk("echo_tap", {ol, orr},
                {(k == 0) ? 24'h100000 : (k == DD) ? 24'h080000 : (k == 2 * DD) ? 24'h040000 : 24'h0, 24'h0});
        end

        // Echo saturation
        pulse_clr();
        for (int k = 0; k <= DD; k++) begin
            do_frame((k == 0 || k == DD) ? 24'h7FFFFF : 24'h0, 24'h0, 3'd4, 1'b0, 0, ol, orr);
        end
        chk("echo_clamp", ol, 24'h7FFFFF);

        // Backpressure, then clear requested alongside an accepted frame
        do_frame(24'h0ABCDE, 24'h012345, 3'd0, 1'b0, 10, ol, orr);
        do_frame(24'h200000, 24'h0, 3'd4, 1'b1, 0, ol, orr);
        wait_clear("clr_frame", 1'b0);
        model_clear();
        for (int k = 0; k <= DD; k++) begin
            do_frame((k == 0) ? 24'h200000 : 24'h0, 24'h0, 3'd4, 1'b0, 0, ol, orr);
            chk("post_clr_tap", ol, (k == 0) ? 24'h200000 : (k == DD) ? 24'h100000 : 24'h0);
        end

        // Randomized frames over all modes
        for (int k = 0; k < 60; k++) begin
            a = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 3)] : 24'($urandom);
            b = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 3)] : 24'($urandom);
            md = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            do_frame(a, b, md, 1'b0, $urandom_range(0, 3), ol, orr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
